// File: rtl/fetch_pc_stage.sv
// Fetch front end: owns the PC, addresses the instruction register and
// fills the IF/ID register under decode back-pressure and redirects.
module fetch_pc_stage #(
    parameter int WORD_SIZE     = 32,
    parameter int REGISTER_SIZE = 64,
    parameter int RESET_PC      = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 fetch_enable,
    input  logic                 redirect_valid,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    output logic [WORD_SIZE-1:0] pc,
    input  logic [WORD_SIZE-1:0] instruction,
    output logic                 id_valid,
    input  logic                 id_ready,
    output logic [WORD_SIZE-1:0] id_instruction,
    output logic [WORD_SIZE-1:0] id_pc,
    output logic [WORD_SIZE-1:0] fetch_count
);

    localparam int AW = $clog2(REGISTER_SIZE);
    localparam logic [AW-1:0] RESET_IDX = AW'(RESET_PC);

    logic [AW-1:0] pc_q;
    logic          load;
    logic          transfer;
    logic          unused_hi;

    // Only the low index bits address the instruction register.
    assign pc        = {{(WORD_SIZE-AW){1'b0}}, pc_q};
    assign unused_hi = ^redirect_pc[WORD_SIZE-1:AW];

    assign load     = !id_valid || id_ready;
    assign transfer = id_valid && id_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q           <= RESET_IDX;
            id_valid       <= 1'b0;
            id_instruction <= '0;
            id_pc          <= '0;
            fetch_count    <= '0;
        end else begin
            if (transfer) begin
                fetch_count <= fetch_count + 1'b1;
            end
            if (redirect_valid) begin
                pc_q     <= redirect_pc[AW-1:0];
                id_valid <= 1'b0;
            end else if (load) begin
                if (fetch_enable) begin
                    id_instruction <= instruction;
                    id_pc          <= pc;
                    id_valid       <= 1'b1;
                    pc_q           <= pc_q + 1'b1;
                end else begin
                    id_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_stage.sv
// Self-checking bench for fetch_pc_stage: vector table through an
// expectation queue, then a randomised back-pressure scoreboard run.
module tb_fetch_pc_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_enable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instruction;
    logic [31:0] id_pc;
    logic [31:0] fetch_count;

    int passed = 0;
    int total  = 0;

    fetch_pc_stage dut (
        .clock          (clock),
        .reset          (reset),
        .fetch_enable   (fetch_enable),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc             (pc),
        .instruction    (instruction),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instruction (id_instruction),
        .id_pc          (id_pc),
        .fetch_count    (fetch_count)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {16'hC0DE, 10'd0, a[5:0]} ^ {a[5:0], 26'd0};
    endfunction

    // Instruction register model: word at pc, visible before next edge.
    assign instruction = mem_f(pc);

    typedef struct {
        logic        rst;
        logic        fe;
        logic        rv;
        logic        rdy;
        logic [31:0] rpc;
        logic        v;
        logic [31:0] ipc;
        logic [31:0] pcx;
        logic [31:0] fc;
    } vec_t;

    vec_t vecs[30];
    vec_t exp_q[$];

    function automatic vec_t vr(
        input logic rst, input logic fe, input logic rv,
        input logic rdy, input int rpc, input logic v,
        input int ipc, input int pcx, input int fc);
        vec_t t;
        t.rst = rst; t.fe = fe; t.rv = rv; t.rdy = rdy;
        t.rpc = 32'(rpc); t.v = v; t.ipc = 32'(ipc);
        t.pcx = 32'(pcx); t.fc = 32'(fc);
        return t;
    endfunction

    task automatic chk(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s row %0d: got %0h want %0h",
                      name, row, act, exp);
    endtask

    initial begin
        int          seq_exp;
        int          xfers;
        logic [31:0] q_pc[$];
        logic [31:0] e;
        bit          saw;

        //        rst fe rv rdy rpc  v  ipc pcx fc
        vecs[0]  = vr(1, 0, 0, 1, 0,  0, 0,  0,  0);
        vecs[1]  = vr(0, 1, 0, 1, 0,  1, 0,  1,  0);
        vecs[2]  = vr(0, 1, 0, 1, 0,  1, 1,  2,  1);
        vecs[3]  = vr(0, 1, 0, 1, 0,  1, 2,  3,  2);
        vecs[4]  = vr(0, 1, 0, 0, 0,  1, 2,  3,  2);
        vecs[5]  = vr(0, 1, 0, 0, 0,  1, 2,  3,  2);
        vecs[6]  = vr(0, 1, 0, 0, 0,  1, 2,  3,  2);
        vecs[7]  = vr(0, 1, 0, 1, 0,  1, 3,  4,  3);
        vecs[8]  = vr(0, 1, 0, 1, 0,  1, 4,  5,  4);
        vecs[9]  = vr(0, 1, 0, 0, 0,  1, 4,  5,  4);
        vecs[10] = vr(0, 1, 1, 0, 40, 0, 0,  40, 4);
        vecs[11] = vr(0, 1, 0, 1, 0,  1, 40, 41, 4);
        vecs[12] = vr(0, 1, 0, 1, 0,  1, 41, 42, 5);
        vecs[13] = vr(0, 1, 1, 1, 62, 0, 0,  62, 6);
        vecs[14] = vr(0, 1, 0, 1, 0,  1, 62, 63, 6);
        vecs[15] = vr(0, 1, 0, 1, 0,  1, 63, 0,  7);
        vecs[16] = vr(0, 1, 0, 1, 0,  1, 0,  1,  8);
        vecs[17] = vr(0, 1, 0, 1, 0,  1, 1,  2,  9);
        vecs[18] = vr(0, 1, 1, 1, 70, 0, 0,  6,  10);
        vecs[19] = vr(0, 1, 0, 1, 0,  1, 6,  7,  10);
        vecs[20] = vr(0, 0, 0, 1, 0,  0, 0,  7,  11);
        vecs[21] = vr(0, 0, 0, 1, 0,  0, 0,  7,  11);
        vecs[22] = vr(0, 1, 0, 1, 0,  1, 7,  8,  11);
        vecs[23] = vr(0, 1, 0, 1, 0,  1, 8,  9,  12);
        vecs[24] = vr(0, 1, 1, 1, 16, 0, 0,  16, 13);
        vecs[25] = vr(0, 1, 0, 1, 0,  1, 16, 17, 13);
        vecs[26] = vr(1, 1, 0, 1, 0,  0, 0,  0,  0);
        vecs[27] = vr(0, 1, 0, 1, 0,  1, 0,  1,  0);
        vecs[28] = vr(0, 0, 0, 0, 0,  1, 0,  1,  0);
        vecs[29] = vr(0, 0, 0, 1, 0,  0, 0,  1,  1);

        reset = 1'b1; fetch_enable = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; id_ready = 1'b0;
        @(posedge clock); #1;

        foreach (vecs[i]) begin
            vec_t x;
            reset          = vecs[i].rst;
            fetch_enable   = vecs[i].fe;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            id_ready       = vecs[i].rdy;
            exp_q.push_back(vecs[i]);
            @(posedge clock); #1;
            x = exp_q.pop_front();
            chk("id_valid", i, {31'd0, id_valid}, {31'd0, x.v});
            chk("pc", i, pc, x.pcx);
            chk("fetch_count", i, fetch_count, x.fc);
            if (x.rst) begin
                chk("id_pc_rst", i, id_pc, 32'd0);
                chk("id_instr_rst", i, id_instruction, 32'd0);
            end else if (x.v) begin
                chk("id_pc", i, id_pc, x.ipc);
                chk("id_instr", i, id_instruction, mem_f(x.ipc));
            end
        end

        // Random back-pressure: every transfer must be the next PC in order.
        reset = 1'b1; redirect_valid = 1'b0; fetch_enable = 1'b1;
        id_ready = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        seq_exp = 0; xfers = 0; saw = 1'b0;
        q_pc.push_back(32'd0);
        for (int c = 0; c < 80; c++) begin
            id_ready = 1'($urandom_range(0, 1));
            if (id_valid) saw = 1'b1;
            if (id_valid && id_ready) begin
                e = q_pc.pop_front();
                chk("sb_id_pc", c, id_pc, e);
                chk("sb_id_instr", c, id_instruction, mem_f(e));
                seq_exp++;
                q_pc.push_back(32'(seq_exp % 64));
                xfers++;
            end
            @(posedge clock); #1;
        end
        chk("sb_saw_valid", 0, {31'd0, saw}, 32'd1);
        chk("sb_fetch_count", 0, fetch_count, 32'(xfers));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_pc_stage.md
# fetch_pc_stage

Instruction-fetch front end that owns the program counter, drives the word address into the instruction register, and captures the returned instruction into an IF/ID pipeline register for the decode stage. It advances the PC one word per accepted fetch, stalls under decode back-pressure, and redirects and flushes on branch or jump requests from downstream. It sits directly upstream of the instruction register and directly upstream of decode.

## Interface
- WORD_SIZE, 32, width of PC and instruction words
- REGISTER_SIZE, 64, number of instruction words addressable; power of two, ≥2
- RESET_PC, 0, PC value loaded on reset; must be < REGISTER_SIZE

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- fetch_enable  in  1  1 = allowed to issue new fetches
- redirect_valid  in  1  branch/jump taken; flush and load redirect_pc
- redirect_pc  in  WORD_SIZE  redirect target, word index
- pc  out  WORD_SIZE  word address to instruction register
- instruction  in  WORD_SIZE  word at pc, returned by instruction register
- id_valid  out  1  IF/ID register holds a valid instruction
- id_ready  in  1  decode accepts IF/ID contents this cycle
- id_instruction  out  WORD_SIZE  captured instruction
- id_pc  out  WORD_SIZE  PC of captured instruction
- fetch_count  out  WORD_SIZE  count of instructions handed to decode

## Operation
- Reset values: pc=RESET_PC, id_valid=0, id_instruction=0, id_pc=0, fetch_count=0.
- Handshake with decode: transfer occurs on a posedge where id_valid=1 and id_ready=1. id_valid, id_instruction and id_pc hold stable while id_valid=1 and id_ready=0.
- Slot open (load) = !id_valid || id_ready.
- Priority per posedge: reset > redirect > load > hold.
- Redirect (redirect_valid=1):
  - pc <= redirect_pc modulo REGISTER_SIZE (low log2(REGISTER_SIZE) bits, upper bits zero).
  - id_valid <= 0, regardless of id_ready or fetch_enable.
  - id_instruction and id_pc are don't-care.
- Load with fetch_enable=1:
  - id_instruction <= instruction, id_pc <= pc, id_valid <= 1.
  - pc <= pc+1, wrapping REGISTER_SIZE-1 -> 0.
- Load with fetch_enable=0: id_valid <= 0 (bubble); pc holds.
- Hold (id_valid=1, id_ready=0, no redirect): all state holds; pc holds.
- fetch_count increments by 1 on every transfer, including a transfer on the same edge as a redirect. It wraps modulo 2^WORD_SIZE and is never cleared except by reset.
- pc is a registered output only; no combinational path from any input to pc.

## Timing
- The instruction register samples pc and presents instruction before the next posedge. The block samples instruction at posedge.
- Fetch latency: pc=P in cycle n -> id_valid=1, id_pc=P, id_instruction=mem[P] in cycle n+1.
- Throughput: 1 instruction/cycle while id_ready=1 and fetch_enable=1.
- Redirect penalty: redirect asserted in cycle n -> pc=target in n+1 -> first target instruction valid in n+2. id_valid=0 in n+1.
- Redirect during stall: the flush wins; the held instruction is discarded without a transfer.
- Reset asserted mid-operation: the next posedge restores all reset values. The first valid instruction appears one cycle after reset deasserts.
- fetch_enable toggling affects only the edge on which it is sampled. No stale instruction is re-captured when fetching resumes.

## Test plan
- Reset, then fetch_enable=1, id_ready=1, mem[0..3]=A,B,C,D: id_pc goes 0,1,2,3 on consecutive cycles starting one cycle after reset; id_instruction=A..D; fetch_count=4 after the fourth transfer.
- Back-pressure: id_ready=0 for 3 cycles while id_pc=2 is valid. id_pc=2 and id_instruction=C hold, pc holds at 3, and fetch_count does not change. Release -> id_pc=3 the next cycle, with no duplicate and no skipped instruction.
- Redirect: redirect_valid=1 with redirect_pc=40 while id_ready=0 and id_valid=1. Next cycle: id_valid=0 and pc=40, with no fetch_count increment. The cycle after: id_pc=40.
- Wrap: redirect to 62 with REGISTER_SIZE=64. id_pc sequence is 62,63,0,1. Also redirect_pc=70 -> pc=6.
- fetch_enable=0 for 2 cycles while id_ready=1: two bubbles (id_valid=0) and pc holds. On re-enable, the next id_pc = the held pc.
- Reset asserted mid-stream at pc=17 with id_valid=1: next cycle pc=RESET_PC, id_valid=0, fetch_count=0.
